// File: rtl/uart_tx_fifo.sv
// Byte FIFO fed by an active-low IO strobe, drained by an 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to build an 8E1 transmitter with an even-parity bit.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          reset,
    input  logic [7:0]                    databus,
    input  logic                          IOload,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          o_tx
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nx;
    logic          ioload_q;
    logic          wr_req, wr_en, pop;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          tx_nx, bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_nx;
`endif

    // Falling edge of the strobe writes once; a full FIFO accepts only if a pop frees a slot
    assign wr_req  = !IOload && ioload_q;
    assign wr_en   = wr_req && (!full || pop);
    assign bit_end = (timer == TW'(CLKS_PER_BIT - 1));

    always_comb begin
        count_nx = count;
        case ({wr_en, pop})
            2'b10:   count_nx = count + CW'(1);
            2'b01:   count_nx = count - CW'(1);
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            ioload_q <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            ioload_q <= IOload;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            count    <= count_nx;
            full     <= (count_nx == CW'(FIFO_DEPTH));
            empty    <= (count_nx == '0);
            overflow <= overflow | (wr_req && full && !pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= databus;
    end

    // Transmit FSM: o_tx is registered from the next-state value
    always_comb begin
        state_nx   = state;
        timer_nx   = timer + TW'(1);
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        tx_nx      = o_tx;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nx     = par_q;
`endif
        case (state)
            IDLE: begin
                timer_nx = '0;
                tx_nx    = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_nx   = mem[rd_ptr];
                    bit_idx_nx = '0;
                    state_nx   = START;
                    tx_nx      = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_nx     = ^mem[rd_ptr];
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    timer_nx = '0;
                    state_nx = DATA;
                    tx_nx    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_nx = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nx = PARITY;
                        tx_nx    = par_q;
`else
                        state_nx = STOP;
                        tx_nx    = 1'b1;
`endif
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        shift_nx   = {1'b0, shift[7:1]};
                        tx_nx      = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    timer_nx = '0;
                    state_nx = STOP;
                    tx_nx    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    timer_nx = '0;
                    state_nx = IDLE;
                    tx_nx    = 1'b1;
                end
            end
            default: begin
                timer_nx = '0;
                state_nx = IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            o_tx    <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            o_tx    <= tx_nx;
            busy    <= (state_nx != IDLE);
`ifdef UART_TX_PARITY_EN
            par_q   <= par_nx;
`endif
        end
    end
endmodule
